evo_gate_array: RTL and testbench
=================================

EVO_GATE_ARRAY -- requirements
Module: evo_gate_array

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, primary input count (>=1).
REQ-002 SHALL have parameter NUM_GATES, default 8, gate cell count (>=1).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16, cell update cycles per evaluation (>=1).
REQ-004 SHALL derive SEL_W = clog2(NUM_INPUTS+NUM_GATES) and GENE_W = 3+2*SEL_W as localparams.
REQ-005 SHALL have ports:
  - clock  in  1  sole clock, rising edge.
  - reset  in  1  synchronous, active-high.
  - in_vec  in  NUM_INPUTS  primary inputs.
  - cfg_valid  in  1  config word offered.
  - cfg_ready  out  1  config word can be accepted.
  - cfg_data  in  GENE_W  config word.
  - cfg_loaded  out  1  one-cycle pulse when a new config is committed.
  - cfg_ok  out  1  a committed config exists.
  - eval_start  in  1  evaluation request.
  - busy  out  1  evaluation in progress.
  - result_valid  out  1  one-cycle result pulse.
  - result  out  1  sampled circuit output.
  - stable  out  1  no cell changed on the final update.
  - cell_state  out  NUM_GATES  current cell values (debug).

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, COMMIT, SETTLE, DONE.
REQ-007 SHALL accept a word when cfg_valid && cfg_ready; cfg_ready = 1 in IDLE and LOAD only.
REQ-008 SHALL write accepted words in order into shadow storage: words 0..NUM_GATES-1 are gene words for cells 0..NUM_GATES-1; word NUM_GATES is the output select (low SEL_W bits used, rest ignored).
REQ-009 Gene layout SHALL be: [2:0] opcode, [SEL_W+2:3] src_a, [2*SEL_W+2:SEL_W+3] src_b.
REQ-010 Opcodes SHALL be: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
REQ-011 A source index below NUM_INPUTS SHALL select the latched input; index k in NUM_INPUTS..NUM_INPUTS+NUM_GATES-1 SHALL select cell k-NUM_INPUTS; larger indices SHALL select constant 0.
REQ-012 IDLE SHALL go to LOAD on the first accepted word; after word NUM_GATES is accepted, the FSM SHALL go to COMMIT.
REQ-013 COMMIT SHALL copy shadow into the active config, clear the word counter, pulse cfg_loaded, set cfg_ok = 1 and return to IDLE; the active config SHALL be unchanged until COMMIT.
REQ-014 eval_start SHALL be accepted only in IDLE with cfg_ok = 1 and cfg_valid = 0; config acceptance has priority when both are asserted; eval_start in any other state SHALL be ignored.
REQ-015 On the accepting edge E0, the block SHALL latch in_vec, clear all cells to 0, clear the update counter, enter SETTLE and set busy = 1.
REQ-016 Edges E1..ES (S = SETTLE_CYCLES) SHALL each update all cells simultaneously from the pre-edge cell values and latched inputs (synchronous evaluation, so feedback loops are deterministic); at ES the FSM SHALL enter DONE.
REQ-017 stable SHALL be 1 iff the update at ES left every cell unchanged.
REQ-018 At edge E(S+1) in DONE, the block SHALL register result = the selected output source, pulse result_valid = 1 for one cycle, clear busy and return to IDLE.
REQ-019 result and stable SHALL hold until the next accepted evaluation; cells SHALL hold their values outside SETTLE.
REQ-020 Changes to in_vec after E0 SHALL NOT affect the running evaluation.

Reset
REQ-021 Reset SHALL force IDLE, clear shadow and active config to all-zero (all cells AND(0,0), out select 0), clear cells and counters, and set cfg_ok = 0, busy = 0, result = 0, stable = 0, result_valid = 0, cfg_loaded = 0; cfg_ready = 1 on the first cycle after reset.
REQ-022 Reset mid-LOAD or mid-SETTLE SHALL discard the partial operation, with no result_valid or cfg_loaded pulse.

Verification
REQ-023 Reset -> all outputs 0 except cfg_ready = 1; eval_start = 1 -> busy stays 0.
REQ-024 Defaults; cell0 = XOR(src 0, src 1), other cells BUF src 0, out select 2; in_vec = 2'b01, eval_start -> result_valid exactly 17 cycles after E0, result = 1, stable = 1.
REQ-025 cell0 = NOT(src 2), out select 2, SETTLE_CYCLES = 16 -> result = 0, stable = 0; with SETTLE_CYCLES = 15 -> result = 1, stable = 0.
REQ-026 cell0 = NAND(src 15, src 15) with NUM_GATES = 8 and NUM_INPUTS = 2 (index out of range) -> result = 1 when out select is 2.
REQ-027 4 of 9 words loaded, then reset -> cfg_ok = 0, no cfg_loaded pulse; a subsequent eval_start is ignored.
REQ-028 cfg_valid and eval_start asserted together in IDLE with cfg_ok = 1 -> word accepted, no evaluation started; eval_start during SETTLE -> ignored, exactly one result_valid pulse.

Source files
------------

// File: rtl/evo_gate_array.sv
// Evolvable gate array: a small array of 2-input gate cells, configured one
// gene word at a time and evaluated synchronously for a fixed number of
// update cycles. The selected output is sampled once the cells have settled.
//
// Ports:
//   clock, reset        sole rising-edge clock, synchronous active-high reset
//   in_vec              primary inputs, latched when an evaluation starts
//   cfg_valid/ready     config word handshake, cfg_data carries the word
//   cfg_loaded          one-cycle pulse when a full config is committed
//   cfg_ok              a committed config exists
//   eval_start          evaluation request (honoured in IDLE only)
//   busy                evaluation in progress
//   result_valid        one-cycle pulse, result/stable valid from here on
//   result, stable      sampled output, no cell changed on the final update
//   cell_state          current cell values (debug)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a config word or an evaluation request
// LOAD    | collecting config words into shadow storage
// COMMIT  | copying shadow into the active config
// SETTLE  | cells updating, one synchronous step per cycle
// DONE    | sampling the selected output source

module evo_gate_array #(
    parameter int  NUM_INPUTS    = 2,
    parameter int  NUM_GATES     = 8,
    parameter int  SETTLE_CYCLES = 16,
    localparam int SEL_W         = $clog2(NUM_INPUTS + NUM_GATES),
    localparam int GENE_W        = 3 + 2 * SEL_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] in_vec,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [GENE_W-1:0]     cfg_data,
    output logic                  cfg_loaded,
    output logic                  cfg_ok,
    input  logic                  eval_start,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  result,
    output logic                  stable,
    output logic [NUM_GATES-1:0]  cell_state
);

    localparam int CNT_W = $clog2(NUM_GATES + 1);
    localparam int UPD_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SRC_N = 1 << SEL_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMMIT, S_SETTLE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic [UPD_W-1:0]      ucnt_q, ucnt_d;
    logic [GENE_W-1:0]     shadow_q [NUM_GATES];
    logic [GENE_W-1:0]     shadow_d [NUM_GATES];
    logic [GENE_W-1:0]     active_q [NUM_GATES];
    logic [GENE_W-1:0]     active_d [NUM_GATES];
    logic [SEL_W-1:0]      osel_sh_q, osel_sh_d;
    logic [SEL_W-1:0]      osel_q, osel_d;
    logic [NUM_INPUTS-1:0] in_lat_q, in_lat_d;
    logic [NUM_GATES-1:0]  cells_q, cells_d;
    logic                  cfg_loaded_q, cfg_loaded_d;
    logic                  cfg_ok_q, cfg_ok_d;
    logic                  busy_q, busy_d;
    logic                  result_valid_q, result_valid_d;
    logic                  result_q, result_d;
    logic                  stable_q, stable_d;

    logic [SRC_N-1:0]      src_pad;
    logic [NUM_GATES-1:0]  next_cells;

    function automatic logic gate_fn(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Source space padded to a power of two: indices past the last cell read
    // the zero padding, which gives the constant-0 source for free.
    always_comb begin
        src_pad = '0;
        src_pad[NUM_INPUTS+NUM_GATES-1:0] = {cells_q, in_lat_q};
        next_cells = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            next_cells[g] = gate_fn(active_q[g][2:0],
                                    src_pad[active_q[g][SEL_W+2:3]],
                                    src_pad[active_q[g][2*SEL_W+2:SEL_W+3]]);
        end
    end

    assign cfg_ready = (state_q == S_IDLE) || (state_q == S_LOAD);

    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        ucnt_d         = ucnt_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        osel_sh_d      = osel_sh_q;
        osel_d         = osel_q;
        in_lat_d       = in_lat_q;
        cells_d        = cells_q;
        cfg_loaded_d   = 1'b0;
        cfg_ok_d       = cfg_ok_q;
        busy_d         = busy_q;
        result_valid_d = 1'b0;
        result_d       = result_q;
        stable_d       = stable_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (cfg_valid) begin
                    for (int i = 0; i < NUM_GATES; i++) begin
                        if (wcnt_q == CNT_W'(i)) shadow_d[i] = cfg_data;
                    end
                    if (wcnt_q == CNT_W'(NUM_GATES)) begin
                        osel_sh_d = cfg_data[SEL_W-1:0];
                        state_d   = S_COMMIT;
                    end else begin
                        wcnt_d  = wcnt_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end else if (state_q == S_IDLE && eval_start && cfg_ok_q) begin
                    in_lat_d = in_vec;
                    cells_d  = '0;
                    ucnt_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            S_COMMIT: begin
                active_d     = shadow_q;
                osel_d       = osel_sh_q;
                wcnt_d       = '0;
                cfg_loaded_d = 1'b1;
                cfg_ok_d     = 1'b1;
                state_d      = S_IDLE;
            end
            S_SETTLE: begin
                cells_d = next_cells;
                if (ucnt_q == UPD_W'(SETTLE_CYCLES - 1)) begin
                    stable_d = (next_cells == cells_q);
                    state_d  = S_DONE;
                end else begin
                    ucnt_d = ucnt_q + 1'b1;
                end
            end
            S_DONE: begin
                result_d       = src_pad[osel_q];
                result_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wcnt_q         <= '0;
            ucnt_q         <= '0;
            shadow_q       <= '{default: '0};
            active_q       <= '{default: '0};
            osel_sh_q      <= '0;
            osel_q         <= '0;
            in_lat_q       <= '0;
            cells_q        <= '0;
            cfg_loaded_q   <= 1'b0;
            cfg_ok_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= 1'b0;
            stable_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            ucnt_q         <= ucnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            osel_sh_q      <= osel_sh_d;
            osel_q         <= osel_d;
            in_lat_q       <= in_lat_d;
            cells_q        <= cells_d;
            cfg_loaded_q   <= cfg_loaded_d;
            cfg_ok_q       <= cfg_ok_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            stable_q       <= stable_d;
        end
    end

    assign cfg_loaded   = cfg_loaded_q;
    assign cfg_ok       = cfg_ok_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign stable       = stable_q;
    assign cell_state   = cells_q;

endmodule

// File: tb/tb_evo_gate_array.sv
module tb_evo_gate_array;

    localparam int NI     = 2;
    localparam int NG     = 8;
    localparam int S      = 16;
    localparam int SEL_W  = 4;
    localparam int GENE_W = 3 + 2 * SEL_W;
    localparam int NSRC   = NI + NG;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NI-1:0]     in_vec = '0;
    logic              cfg_valid = 1'b0;
    logic [GENE_W-1:0] cfg_data = '0;
    logic              eval_start = 1'b0;

    logic          cfg_ready, cfg_loaded, cfg_ok, busy, result_valid, result, stable;
    logic [NG-1:0] cell_state;
    logic          cfg_ready_b, cfg_loaded_b, cfg_ok_b, busy_b, result_valid_b, result_b, stable_b;
    logic [NG-1:0] cell_state_b;

    evo_gate_array #(.NUM_INPUTS(NI), .NUM_GATES(NG), .SETTLE_CYCLES(S)) dut (
        .clock(clock), .reset(reset), .in_vec(in_vec),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .cfg_loaded(cfg_loaded), .cfg_ok(cfg_ok), .eval_start(eval_start),
        .busy(busy), .result_valid(result_valid), .result(result),
        .stable(stable), .cell_state(cell_state));

    // Same stimulus, one fewer settle cycle.
    evo_gate_array #(.NUM_INPUTS(NI), .NUM_GATES(NG), .SETTLE_CYCLES(S-1)) dut_b (
        .clock(clock), .reset(reset), .in_vec(in_vec),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b), .cfg_data(cfg_data),
        .cfg_loaded(cfg_loaded_b), .cfg_ok(cfg_ok_b), .eval_start(eval_start),
        .busy(busy_b), .result_valid(result_valid_b), .result(result_b),
        .stable(stable_b), .cell_state(cell_state_b));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int rv_cnt = 0, rv_cnt_b = 0, cl_cnt = 0;

    always @(negedge clock) begin
        if (result_valid === 1'b1) rv_cnt++;
        if (result_valid_b === 1'b1) rv_cnt_b++;
        if (cfg_loaded === 1'b1) cl_cnt++;
    end

    int g_op [NG];
    int g_a  [NG];
    int g_b  [NG];
    int osel_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int src_val(input int idx, input logic [NI-1:0] inv, input logic [NG-1:0] cells);
        if (idx < NI) return int'(inv[idx]);
        if (idx < NSRC) return int'(cells[idx-NI]);
        return 0;
    endfunction

    function automatic int gate(input int op, input int a, input int b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return 1 - (a & b);
            3: return 1 - (a | b);
            4: return a ^ b;
            5: return 1 - (a ^ b);
            6: return 1 - a;
            default: return a;
        endcase
    endfunction

    // Run s synchronous steps from all-zero cells and sample the output.
    task automatic model(input logic [NI-1:0] inv, input int s, output int res,
                         output int stab, output logic [NG-1:0] fin);
        logic [NG-1:0] cells, nxt;
        cells = '0;
        stab = 0;
        for (int step = 0; step < s; step++) begin
            for (int g = 0; g < NG; g++)
                nxt[g] = gate(g_op[g], src_val(g_a[g], inv, cells), src_val(g_b[g], inv, cells)) != 0;
            stab = (nxt == cells) ? 1 : 0;
            cells = nxt;
        end
        res = src_val(osel_word % (1 << SEL_W), inv, cells);
        fin = cells;
    endtask

    function automatic logic [GENE_W-1:0] word_of(input int w);
        int v;
        if (w < NG) v = g_op[w] + (g_a[w] << 3) + (g_b[w] << (3 + SEL_W));
        else v = osel_word;
        return GENE_W'(v);
    endfunction

    task automatic set_default_cfg();
        for (int g = 0; g < NG; g++) begin
            g_op[g] = 0; g_a[g] = 0; g_b[g] = 0;
        end
        osel_word = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; cfg_valid = 1'b0; eval_start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load_cfg(input int first, input int last);
        bit seen;
        for (int w = first; w <= last; w++) begin
            @(negedge clock);
            cfg_valid = 1'b1;
            cfg_data = word_of(w);
            chk("cfg_ready_load", cfg_ready, 1);
        end
        @(negedge clock);
        cfg_valid = 1'b0;
        if (last == NG) begin
            seen = 0;
            for (int c = 0; c < 4 && !seen; c++) begin
                @(posedge clock); #1;
                if (cfg_loaded) seen = 1;
            end
            chk("cfg_loaded_seen", seen, 1);
            chk("cfg_ok_after_load", cfg_ok, 1);
        end
    endtask

    task automatic run_eval(input logic [NI-1:0] inv, input bit hold_start);
        int er, es, er_b, es_b, rv0, rvb0, lat, lat_b;
        logic [NG-1:0] ec, ec_b, got_c, got_c_b;
        logic got_r, got_s, got_r_b, got_s_b;
        model(inv, S, er, es, ec);
        model(inv, S - 1, er_b, es_b, ec_b);
        rv0 = rv_cnt; rvb0 = rv_cnt_b;
        lat = 0; lat_b = 0;
        got_r = 0; got_s = 0; got_c = '0; got_r_b = 0; got_s_b = 0; got_c_b = '0;
        @(negedge clock);
        cfg_valid = 1'b0; in_vec = inv; eval_start = 1'b1;
        @(posedge clock); #1;
        chk("busy_at_start", busy, 1);
        chk("busy_at_start_b", busy_b, 1);
        @(negedge clock);
        eval_start = hold_start;
        in_vec = ~inv;
        for (int c = 1; c <= 60 && (lat == 0 || lat_b == 0); c++) begin
            @(posedge clock); #1;
            if (c == 5) eval_start = 1'b0;
            if (result_valid && lat == 0) begin
                lat = c; got_r = result; got_s = stable; got_c = cell_state;
            end
            if (result_valid_b && lat_b == 0) begin
                lat_b = c; got_r_b = result_b; got_s_b = stable_b; got_c_b = cell_state_b;
            end
        end
        eval_start = 1'b0;
        chk("latency", lat, S + 1);
        chk("latency_b", lat_b, S);
        chk("result", got_r, er);
        chk("stable", got_s, es);
        chk("cells", got_c, ec);
        chk("result_b", got_r_b, er_b);
        chk("stable_b", got_s_b, es_b);
        chk("cells_b", got_c_b, ec_b);
        repeat (3) @(negedge clock);
        chk("result_hold", result, er);
        chk("busy_after", busy, 0);
        chk("rv_pulses", rv_cnt - rv0, 1);
        chk("rv_pulses_b", rv_cnt_b - rvb0, 1);
    endtask

    initial begin
        int cl0, rv0;
        do_reset();
        #1;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_cfg_loaded", cfg_loaded, 0);
        chk("rst_cfg_ok", cfg_ok, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_stable", stable, 0);
        chk("rst_cells", cell_state, 0);
        @(negedge clock);
        eval_start = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            chk("no_eval_without_cfg", busy, 0);
        end
        eval_start = 1'b0;

        // XOR of both inputs on cell 0, everything else buffers input 0.
        set_default_cfg();
        g_op[0] = 4; g_a[0] = 0; g_b[0] = 1;
        for (int g = 1; g < NG; g++) g_op[g] = 7;
        osel_word = 2;
        load_cfg(0, NG);
        run_eval(2'b01, 0);
        chk("xor_result_const", result, 1);
        chk("xor_stable_const", stable, 1);

        // Self-inverting cell: parity of settle count decides the result.
        set_default_cfg();
        g_op[0] = 6; g_a[0] = 2; osel_word = 2;
        load_cfg(0, NG);
        run_eval(2'b10, 0);
        chk("not_loop_result", result, 0);
        chk("not_loop_result_b", result_b, 1);
        chk("not_loop_stable", stable, 0);

        // Out-of-range source reads constant 0.
        set_default_cfg();
        g_op[0] = 2; g_a[0] = 15; g_b[0] = 15; osel_word = 2;
        load_cfg(0, NG);
        run_eval(2'b11, 0);
        chk("oor_result", result, 1);

        // Simultaneous cfg_valid and eval_start: config wins.
        set_default_cfg();
        g_op[0] = 1; g_a[0] = 0; g_b[0] = 1; osel_word = 2;
        @(negedge clock);
        cfg_valid = 1'b1; cfg_data = word_of(0); eval_start = 1'b1; in_vec = 2'b10;
        @(posedge clock); #1;
        chk("cfg_priority_busy", busy, 0);
        chk("cfg_priority_ready", cfg_ready, 1);
        eval_start = 1'b0;
        load_cfg(1, NG);
        run_eval(2'b10, 1);

        // Partial load then reset.
        cl0 = cl_cnt;
        load_cfg(0, 3);
        do_reset();
        repeat (4) @(negedge clock);
        chk("partial_no_loaded", cl_cnt - cl0, 0);
        chk("partial_cfg_ok", cfg_ok, 0);
        eval_start = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            chk("partial_eval_ignored", busy, 0);
        end
        eval_start = 1'b0;

        // Reset mid-settle.
        load_cfg(0, NG);
        @(negedge clock);
        eval_start = 1'b1;
        @(negedge clock);
        eval_start = 1'b0;
        repeat (5) @(negedge clock);
        rv0 = rv_cnt;
        do_reset();
        repeat (30) @(negedge clock);
        chk("settle_reset_no_rv", rv_cnt - rv0, 0);
        chk("settle_reset_busy", busy, 0);

        // Random configurations, including out-of-range sources.
        for (int t = 0; t < 25; t++) begin
            for (int g = 0; g < NG; g++) begin
                g_op[g] = int'($urandom_range(0, 7));
                g_a[g]  = int'($urandom_range(0, 15));
                g_b[g]  = int'($urandom_range(0, 15));
            end
            osel_word = int'($urandom_range(0, (1 << GENE_W) - 1));
            load_cfg(0, NG);
            run_eval(NI'($urandom_range(0, 3)), 0);
            run_eval(NI'($urandom_range(0, 3)), t[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
